// File: rtl/alu_ex_stage_pkg.sv
// Shared definitions for the EX stage: ALU operation codes (also consumed by
// ALU_control) and datapath widths.
package alu_ex_stage_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned SHAMT_W    = 5;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_NOR  = 4'd5,
        OP_SLT  = 4'd6,
        OP_SLL  = 4'd7,
        OP_SRL  = 4'd8,
        OP_SRA  = 4'd9,
        OP_SLLV = 4'd10,
        OP_SRLV = 4'd11,
        OP_SRAV = 4'd12,
        OP_ADDU = 4'd13,
        OP_SUBU = 4'd14,
        OP_LUI  = 4'd15
    } alu_op_e;

    function automatic logic is_zero(input logic [DATA_W-1:0] value);
        return (value == {DATA_W{1'b0}});
    endfunction

endpackage

// File: rtl/alu_ex_stage_alu.sv
// Combinational ALU: operation, operands and shift amount to result plus
// signed-overflow flag (raised only by ADD and SUB).
module alu
    import alu_ex_stage_pkg::*;
(
    input  logic [3:0]         i_operation,
    input  logic [DATA_W-1:0]  i_data_a,
    input  logic [DATA_W-1:0]  i_data_b,
    input  logic [SHAMT_W-1:0] i_shamt,
    output logic [DATA_W-1:0]  o_result,
    output logic               o_overflow
);

    alu_op_e             w_op;
    logic [DATA_W-1:0]   w_sum;
    logic [DATA_W-1:0]   w_diff;
    logic [SHAMT_W-1:0]  w_var_shamt;

    assign w_op        = alu_op_e'(i_operation);
    assign w_sum       = i_data_a + i_data_b;
    assign w_diff      = i_data_a - i_data_b;
    assign w_var_shamt = i_data_a[SHAMT_W-1:0];

    // Operation decode; the adder/subtractor outputs are shared by the
    // trapping and non-trapping variants, only ADD/SUB report overflow.
    always_comb begin
        o_result   = {DATA_W{1'b0}};
        o_overflow = 1'b0;
        case (w_op)
            OP_ADD: begin
                o_result   = w_sum;
                o_overflow = (i_data_a[DATA_W-1] == i_data_b[DATA_W-1]) &&
                             (w_sum[DATA_W-1] != i_data_a[DATA_W-1]);
            end
            OP_SUB: begin
                o_result   = w_diff;
                o_overflow = (i_data_a[DATA_W-1] != i_data_b[DATA_W-1]) &&
                             (w_diff[DATA_W-1] != i_data_a[DATA_W-1]);
            end
            OP_AND:  o_result = i_data_a & i_data_b;
            OP_OR:   o_result = i_data_a | i_data_b;
            OP_XOR:  o_result = i_data_a ^ i_data_b;
            OP_NOR:  o_result = ~(i_data_a | i_data_b);
            OP_SLT:  o_result = {{(DATA_W-1){1'b0}}, ($signed(i_data_a) < $signed(i_data_b))};
            OP_SLL:  o_result = i_data_b << i_shamt;
            OP_SRL:  o_result = i_data_b >> i_shamt;
            OP_SRA:  o_result = $unsigned($signed(i_data_b) >>> i_shamt);
            OP_SLLV: o_result = i_data_b << w_var_shamt;
            OP_SRLV: o_result = i_data_b >> w_var_shamt;
            OP_SRAV: o_result = $unsigned($signed(i_data_b) >>> w_var_shamt);
            OP_ADDU: o_result = w_sum;
            OP_SUBU: o_result = w_diff;
            OP_LUI:  o_result = {i_data_b[15:0], 16'h0000};
            default: begin
                o_result   = {DATA_W{1'b0}};
                o_overflow = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_ex_stage.sv
// EX pipeline stage: ALU followed by the EX/MEM register with
// reset > flush > stall > load priority.
module alu_ex_stage
    import alu_ex_stage_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_valid,
    input  logic [3:0]            i_operation,
    input  logic [DATA_W-1:0]     i_data_a,
    input  logic [DATA_W-1:0]     i_data_b,
    input  logic [SHAMT_W-1:0]    i_shamt,
    input  logic [REG_ADDR_W-1:0] i_rd_addr,
    input  logic                  i_reg_write,
    input  logic                  i_stall,
    input  logic                  i_flush,
    output logic                  o_valid,
    output logic [DATA_W-1:0]     o_result,
    output logic                  o_zero,
    output logic                  o_overflow,
    output logic [REG_ADDR_W-1:0] o_rd_addr,
    output logic                  o_reg_write
);

    logic [DATA_W-1:0]     w_alu_result;
    logic                  w_alu_overflow;
    logic                  w_load_overflow;
    logic                  w_load_reg_write;

    logic                  r_valid;
    logic [DATA_W-1:0]     r_result;
    logic                  r_zero;
    logic                  r_overflow;
    logic [REG_ADDR_W-1:0] r_rd_addr;
    logic                  r_reg_write;

    alu u_alu (
        .i_operation (i_operation),
        .i_data_a    (i_data_a),
        .i_data_b    (i_data_b),
        .i_shamt     (i_shamt),
        .o_result    (w_alu_result),
        .o_overflow  (w_alu_overflow)
    );

    // A trapping instruction still occupies the slot but must not write back;
    // register 0 is never written.
    assign w_load_overflow  = i_valid & w_alu_overflow;
    assign w_load_reg_write = i_valid & i_reg_write & ~w_alu_overflow &
                              (i_rd_addr != {REG_ADDR_W{1'b0}});

    // EX/MEM register; zero flag is registered from the same value as the result.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            r_valid     <= 1'b0;
            r_result    <= {DATA_W{1'b0}};
            r_zero      <= 1'b1;
            r_overflow  <= 1'b0;
            r_rd_addr   <= {REG_ADDR_W{1'b0}};
            r_reg_write <= 1'b0;
        end else if (i_stall) begin
            r_valid     <= r_valid;
            r_result    <= r_result;
            r_zero      <= r_zero;
            r_overflow  <= r_overflow;
            r_rd_addr   <= r_rd_addr;
            r_reg_write <= r_reg_write;
        end else begin
            r_valid     <= i_valid;
            r_result    <= w_alu_result;
            r_zero      <= is_zero(w_alu_result);
            r_overflow  <= w_load_overflow;
            r_rd_addr   <= i_rd_addr;
            r_reg_write <= w_load_reg_write;
        end
    end

    assign o_valid     = r_valid;
    assign o_result    = r_result;
    assign o_zero      = r_zero;
    assign o_overflow  = r_overflow;
    assign o_rd_addr   = r_rd_addr;
    assign o_reg_write = r_reg_write;

endmodule

// File: tb/tb_alu_ex_stage.sv
// Scoreboard bench for alu_ex_stage: each driven cycle pushes the expected
// EX/MEM contents, which are popped and compared one edge later.
module tb_alu_ex_stage;

    typedef struct packed {
        logic        valid;
        logic [31:0] result;
        logic        zero;
        logic        ovf;
        logic [4:0]  rd;
        logic        rw;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, valid, reg_write, stall, flush;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [4:0]  shamt, rd;
    logic        o_valid, o_zero, o_overflow, o_reg_write;
    logic [31:0] o_result;
    logic [4:0]  o_rd_addr;

    exp_t        sb_q[$];
    exp_t        mdl;
    int          n_total = 0;
    int          n_pass  = 0;

    alu_ex_stage dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_valid     (valid),
        .i_operation (op),
        .i_data_a    (a),
        .i_data_b    (b),
        .i_shamt     (shamt),
        .i_rd_addr   (rd),
        .i_reg_write (reg_write),
        .i_stall     (stall),
        .i_flush     (flush),
        .o_valid     (o_valid),
        .o_result    (o_result),
        .o_zero      (o_zero),
        .o_overflow  (o_overflow),
        .o_rd_addr   (o_rd_addr),
        .o_reg_write (o_reg_write)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, want);
    endtask

    // Reference ALU using wide signed arithmetic for overflow.
    function automatic logic [31:0] ref_alu(input logic [3:0] f_op, input logic [31:0] f_a,
                                            input logic [31:0] f_b, input logic [4:0] f_sh,
                                            output logic f_ovf);
        longint      s;
        logic [31:0] r;
        logic [4:0]  vs;
        logic [31:0] ones;
        ones  = 32'hFFFF_FFFF;
        f_ovf = 1'b0;
        vs    = f_a[4:0];
        r     = 32'd0;
        case (f_op)
            4'd0: begin
                s = longint'($signed(f_a)) + longint'($signed(f_b));
                r = s[31:0];
                f_ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd1: begin
                s = longint'($signed(f_a)) - longint'($signed(f_b));
                r = s[31:0];
                f_ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd2:  r = f_a & f_b;
            4'd3:  r = f_a | f_b;
            4'd4:  r = f_a ^ f_b;
            4'd5:  r = ~(f_a | f_b);
            4'd6:  r = ($signed(f_a) < $signed(f_b)) ? 32'd1 : 32'd0;
            4'd7:  r = f_b << f_sh;
            4'd8:  r = f_b >> f_sh;
            4'd9:  r = (f_b >> f_sh) | (f_b[31] ? ~(ones >> f_sh) : 32'd0);
            4'd10: r = f_b << vs;
            4'd11: r = f_b >> vs;
            4'd12: r = (f_b >> vs) | (f_b[31] ? ~(ones >> vs) : 32'd0);
            4'd13: r = f_a + f_b;
            4'd14: r = f_a - f_b;
            4'd15: r = {f_b[15:0], 16'h0000};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Drive one cycle, push the expected EX/MEM state, and compare after the edge.
    task automatic step(input logic t_rst, input logic t_v, input logic [3:0] t_op,
                        input logic [31:0] t_a, input logic [31:0] t_b, input logic [4:0] t_sh,
                        input logic [4:0] t_rd, input logic t_rw, input logic t_st, input logic t_fl);
        exp_t        e;
        logic        ovf;
        logic [31:0] r;
        exp_t        got;
        reset = t_rst; valid = t_v; op = t_op; a = t_a; b = t_b; shamt = t_sh;
        rd = t_rd; reg_write = t_rw; stall = t_st; flush = t_fl;
        r = ref_alu(t_op, t_a, t_b, t_sh, ovf);
        if (t_rst || t_fl) begin
            e = '{valid: 1'b0, result: 32'd0, zero: 1'b1, ovf: 1'b0, rd: 5'd0, rw: 1'b0};
        end else if (t_st) begin
            e = mdl;
        end else begin
            e.valid  = t_v;
            e.result = r;
            e.zero   = (r == 32'd0);
            e.ovf    = t_v && ovf;
            e.rd     = t_rd;
            e.rw     = t_v && t_rw && !ovf && (t_rd != 5'd0);
        end
        mdl = e;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check_eq("sb_empty", 32'd0, 32'd1);
        end else begin
            got = sb_q.pop_front();
            check_eq("valid",  32'(o_valid),     32'(got.valid));
            check_eq("result", o_result,         got.result);
            check_eq("zero",   32'(o_zero),      32'(got.zero));
            check_eq("ovf",    32'(o_overflow),  32'(got.ovf));
            check_eq("rd",     32'(o_rd_addr),   32'(got.rd));
            check_eq("rw",     32'(o_reg_write), 32'(got.rw));
            check_eq("zero_consistent", 32'(o_zero), 32'(o_result == 32'd0));
        end
    endtask

    initial begin
        logic [31:0] ra, rb;
        mdl = '{valid: 1'b0, result: 32'd0, zero: 1'b1, ovf: 1'b0, rd: 5'd0, rw: 1'b0};
        reset = 1'b1; valid = 1'b0; op = 4'd0; a = 32'd0; b = 32'd0; shamt = 5'd0;
        rd = 5'd0; reg_write = 1'b0; stall = 1'b0; flush = 1'b0;

        step(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        check_eq("reset_zero", 32'(o_zero), 32'd1);

        // Signed overflow on ADD traps write-back; ADDU does not.
        step(1'b0, 1'b1, 4'd0, 32'h7FFF_FFFF, 32'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
        check_eq("add_ovf_res", o_result, 32'h8000_0000);
        check_eq("add_ovf_flag", 32'(o_overflow), 32'd1);
        step(1'b0, 1'b1, 4'd13, 32'h7FFF_FFFF, 32'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
        check_eq("addu_rw", 32'(o_reg_write), 32'd1);
        step(1'b0, 1'b1, 4'd1, 32'h8000_0000, 32'd1, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'd14, 32'h8000_0000, 32'd1, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0);

        // Shifts.
        step(1'b0, 1'b1, 4'd9, 32'd0, 32'hF000_0000, 5'd4, 5'd7, 1'b1, 1'b0, 1'b0);
        check_eq("sra_res", o_result, 32'hFF00_0000);
        step(1'b0, 1'b1, 4'd12, 32'd4, 32'hF000_0000, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0);
        check_eq("srav_res", o_result, 32'hFF00_0000);
        step(1'b0, 1'b1, 4'd8, 32'd0, 32'hF000_0000, 5'd4, 5'd7, 1'b1, 1'b0, 1'b0);
        check_eq("srl_res", o_result, 32'h0F00_0000);
        step(1'b0, 1'b1, 4'd7, 32'd0, 32'h0000_0003, 5'd31, 5'd7, 1'b1, 1'b0, 1'b0);

        // SLT signed compare and SUB to zero.
        step(1'b0, 1'b1, 4'd6, 32'hFFFF_FFFF, 32'd1, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0);
        check_eq("slt_res", o_result, 32'd1);
        step(1'b0, 1'b1, 4'd1, 32'd7, 32'd7, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0);
        check_eq("sub_zero", 32'(o_zero), 32'd1);

        // Write to r0 and an invalid slot both suppress write-back.
        step(1'b0, 1'b1, 4'd3, 32'h1, 32'h2, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'd0, 32'h7FFF_FFFF, 32'd1, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0);

        // Hold for three stalled cycles while inputs change, then flush wins over stall.
        step(1'b0, 1'b1, 4'd0, 32'd2, 32'd3, 5'd0, 5'd10, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 4'(i + 2), 32'(i * 17 + 1), 32'(i + 100), 5'(i), 5'(i + 1), 1'b1, 1'b1, 1'b0);
            check_eq("stall_hold", o_result, 32'd5);
        end
        step(1'b0, 1'b1, 4'd0, 32'd9, 32'd9, 5'd0, 5'd11, 1'b1, 1'b1, 1'b1);
        check_eq("flush_valid", 32'(o_valid), 32'd0);

        // Reset discards the in-flight instruction; LUI follows immediately.
        step(1'b0, 1'b1, 4'd4, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 5'd0, 5'd12, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 4'd0, 32'd1, 32'd1, 5'd0, 5'd12, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'd15, 32'hDEAD_BEEF, 32'h0000_1234, 5'd0, 5'd13, 1'b1, 1'b0, 1'b0);
        check_eq("lui_res", o_result, 32'h1234_0000);

        // Every opcode with random operands and occasional stall/flush/reset.
        for (int i = 0; i < 96; i++) begin
            ra = (i % 7 == 0) ? 32'h8000_0000 : $urandom();
            rb = (i % 5 == 0) ? 32'h7FFF_FFFF : $urandom();
            step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0), 4'(i % 16), ra, rb,
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_ex_stage.md
ALU_EX_STAGE -- requirements
Module: alu_ex_stage

Interface
REQ-001 SHALL have exactly one clock and one reset: reset synchronous, active-high.
REQ-002 i_clk  input  1  rising-edge clock.
REQ-003 i_reset  input  1  synchronous active-high reset.
REQ-004 i_valid  input  1  ID/EX slot holds a real instruction.
REQ-005 i_operation  input  4  ALU operation code from ALU_control.
REQ-006 i_data_a  input  32  rs operand.
REQ-007 i_data_b  input  32  rt operand or extended immediate.
REQ-008 i_shamt  input  5  instruction shamt field.
REQ-009 i_rd_addr  input  5  destination register.
REQ-010 i_reg_write  input  1  instruction writes the register file.
REQ-011 i_stall  input  1  hold EX/MEM register.
REQ-012 i_flush  input  1  replace the incoming instruction with a bubble.
REQ-013 o_valid  output  1  EX/MEM slot valid.
REQ-014 o_result  output  32  registered ALU result.
REQ-015 o_zero  output  1  registered (o_result == 0).
REQ-016 o_overflow  output  1  registered signed-overflow flag.
REQ-017 o_rd_addr  output  5  registered destination.
REQ-018 o_reg_write  output  1  registered write enable, overflow-qualified.

Function
REQ-019 Operation codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLL, 8 SRL, 9 SRA, 10 SLLV, 11 SRLV, 12 SRAV, 13 ADDU, 14 SUBU, 15 LUI.
REQ-020 Latency SHALL be exactly one cycle: inputs sampled on edge N appear on outputs after edge N.
REQ-021 SLT: result is 32'd1 if signed a < b, else 32'd0.
REQ-022 SLL/SRL/SRA shift b by i_shamt; SLLV/SRLV/SRAV shift b by a[4:0]; SRA/SRAV replicate b[31].
REQ-023 LUI: result = {b[15:0], 16'h0000}; a ignored.
REQ-024 ADD/ADDU/SUB/SUBU results wrap modulo 2^32.
REQ-025 Overflow is computed only for ADD and SUB: the operands have the same sign (ADD) or opposite signs (SUB) and the result sign differs from a's sign.
REQ-026 On overflow: o_overflow = 1, o_reg_write = 0, o_valid = 1, and o_result is still the wrapped value.
REQ-027 ADDU/SUBU/all other ops SHALL force o_overflow = 0.
REQ-028 When i_valid = 0: o_valid, o_reg_write and o_overflow are 0 after the edge; o_result is don't-care but deterministic (computed normally).
REQ-029 When i_stall = 1 and i_flush = 0: all output registers hold their value.
REQ-030 When i_flush = 1: a bubble is loaded (o_valid = 0, o_reg_write = 0, o_overflow = 0, o_result = 0, o_rd_addr = 0), regardless of i_stall.
REQ-031 Priority SHALL be reset > flush > stall > load.
REQ-032 A write to register 0 (i_rd_addr = 0) SHALL force o_reg_write = 0.
REQ-033 o_zero SHALL be derived from the registered result and SHALL be consistent with o_result in every cycle.

Reset
REQ-034 On i_reset = 1 at an edge, outputs SHALL become: o_valid 0, o_result 0, o_zero 1, o_overflow 0, o_rd_addr 0, o_reg_write 0.
REQ-035 Reset mid-operation SHALL discard the in-flight instruction; the first edge after reset deasserts samples inputs normally.

Structure
REQ-036 The 4-bit operation codes SHALL live in a shared package/include, also used by ALU_control.
REQ-037 The combinational ALU (operation, a, b, shamt -> result, overflow) SHALL be a sub-module named alu; alu_ex_stage contains only it plus the EX/MEM register and control.

Verification
REQ-038 ADD a=32'h7FFFFFFF, b=1, rd=5, reg_write=1 -> next cycle result 32'h80000000, overflow 1, reg_write 0, valid 1.
REQ-039 ADDU with the same operands -> result 32'h80000000, overflow 0, reg_write 1.
REQ-040 SRA b=32'hF0000000, shamt=4 -> 32'hFF000000; SRAV a=4, same b -> 32'hFF000000; SRL shamt=4 -> 32'h0F000000.
REQ-041 SLT a=32'hFFFFFFFF, b=1 -> result 1; SUB a=b=7 -> result 0, zero 1.
REQ-042 Load ADD 2+3, then stall 3 cycles while the inputs change -> result held at 5 for all 3 cycles; then assert stall and flush together -> bubble, valid 0.
REQ-043 Assert reset while a valid instruction is in EX/MEM -> all outputs take the reset values of REQ-034 on that edge; a LUI b=16'h1234 issued on the next cycle -> 32'h12340000.
